barrel_shift_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational barrel shifter among `NREQ` requesters. Each requester presents a data word and a shift amount through a valid/ready handshake. The block grants one request at a time and drives the shifter from registered operands. It captures the shifter output and returns it on a single response channel, tagged with the requester ID. It sits between the requesting units and the shifter instance, which remains a pure combinational datapath outside this block.

---
 rtl/barrel_shift_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter that time-shares one external combinational barrel shifter
// among NREQ requesters, returning each tagged result on a single response channel.
module barrel_shift_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    input  logic [NREQ*SHW-1:0]    req_shift,
    output logic [WIDTH-1:0]       sh_data_in,
    output logic [SHW-1:0]         sh_shifts,
    input  logic [WIDTH-1:0]       sh_data_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [IDW-1:0]     last_grant_reg;
    logic [IDW-1:0]     op_id_reg;
    logic [WIDTH-1:0]   op_data_reg;
    logic [SHW-1:0]     op_shift_reg;
    logic [WIDTH-1:0]   rsp_data_reg;
    logic [IDW-1:0]     rsp_id_reg;
    logic               rsp_valid_reg;
    logic               busy_reg;

    logic [WIDTH-1:0]   data_arr  [NREQ];
    logic [SHW-1:0]     shift_arr [NREQ];
    logic [IDW-1:0]     cand_idx  [NREQ];
    logic [NREQ-1:0]    cand_hit;
    logic [IDW-1:0]     winner;
    logic               grant_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi]  = req_data[gi*WIDTH +: WIDTH];
            assign shift_arr[gi] = req_shift[gi*SHW +: SHW];
        end

        // Candidate gi is the requester gi+1 positions after the last grant, modulo NREQ.
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum = {1'b0, last_grant_reg} + (IDW+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                           : sum[IDW-1:0];
            assign cand_hit[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    // Lowest candidate offset wins; iterating downward lets it overwrite the rest.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_valid = 1'b1;
                winner      = cand_idx[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_reg == IDLE && grant_valid) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDW'(NREQ - 1);
            op_id_reg      <= '0;
            op_data_reg    <= '0;
            op_shift_reg   <= '0;
            rsp_data_reg   <= '0;
            rsp_id_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        op_data_reg    <= data_arr[winner];
                        op_shift_reg   <= shift_arr[winner];
                        op_id_reg      <= winner;
                        last_grant_reg <= winner;
                        busy_reg       <= 1'b1;
                        state_reg      <= SHIFT;
                    end
                end
                SHIFT: begin
                    rsp_data_reg  <= sh_data_out;
                    rsp_id_reg    <= op_id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // Operand registers feed the shifter directly, so they only change on an accept.
    assign sh_data_in = op_data_reg;
    assign sh_shifts  = op_shift_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_id     = rsp_id_reg;
    assign busy       = busy_reg;

endmodule
